// File: rtl/wishbone_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_rr_arbiter
//   Shares one pipelined Wishbone slave between N_MASTERS pipelined masters.
//   The owner keeps its tenure until it drops m_cyc. MODE 0 picks the next
//   owner round-robin, and MODE 1 picks it by fixed priority (index 0 highest).
//   A per-tenure counter limits outstanding strobes to MAX_OUT.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   m_cyc/m_stb/m_we [N]       per-master request controls
//   m_adr [N*ADR_W]            per-master address, master i at [i*ADR_W +: ADR_W]
//   m_dat_w [N*DAT_W]          per-master write data, same slicing
//   m_dat_r [DAT_W]            slave read data broadcast to all masters
//   m_ack/m_stall [N]          per-master response
//   s_cyc/s_stb/s_we/s_adr/s_dat_w  muxed request to the slave
//   s_ack/s_stall/s_dat_r      slave response
//   grant [N]                  registered one-hot owner, zero when idle
//   busy                       high while a tenure is granted
//
// state   | meaning
// IDLE    | no owner; arbitrate on any m_cyc at the next edge
// GRANTED | grant holds the owner until its m_cyc is sampled low
// -----------------------------------------------------------------------------
module wishbone_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADR_W     = 16,
  parameter int DAT_W     = 16,
  parameter int MODE      = 0,
  parameter int MAX_OUT   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_MASTERS-1:0]       m_cyc,
  input  logic [N_MASTERS-1:0]       m_stb,
  input  logic [N_MASTERS-1:0]       m_we,
  input  logic [N_MASTERS*ADR_W-1:0] m_adr,
  input  logic [N_MASTERS*DAT_W-1:0] m_dat_w,
  output logic [DAT_W-1:0]           m_dat_r,
  output logic [N_MASTERS-1:0]       m_ack,
  output logic [N_MASTERS-1:0]       m_stall,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [ADR_W-1:0]           s_adr,
  output logic [DAT_W-1:0]           s_dat_w,
  input  logic                       s_ack,
  input  logic                       s_stall,
  input  logic [DAT_W-1:0]           s_dat_r,
  output logic [N_MASTERS-1:0]       grant,
  output logic                       busy
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   cnt_next;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   rr_next;
  logic [PW-1:0]   scan_idx;
  logic            win_found;
  logic            owner_cyc;
  logic            owner_stb;
  logic            cnt_full;
  logic            strb_acc;
  logic            ack_in;

  assign busy      = (state == GRANTED);
  // grant is all zeros while idle, so every owner-masked term below is
  // automatically inactive outside a tenure.
  assign owner_cyc = |(m_cyc & grant);
  assign owner_stb = |(m_stb & grant);
  assign cnt_full  = (out_cnt == MAX_CNT);

  assign s_cyc   = busy & owner_cyc;
  assign s_stb   = busy & owner_stb & (out_cnt < MAX_CNT);
  assign s_we    = |(m_we & grant);
  assign m_stall = ~grant | {N_MASTERS{s_stall | cnt_full}};
  assign m_ack   = grant & {N_MASTERS{s_ack & busy}};
  assign m_dat_r = s_dat_r;

  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant[i]) begin
        s_adr   = s_adr   | m_adr[i*ADR_W +: ADR_W];
        s_dat_w = s_dat_w | m_dat_w[i*DAT_W +: DAT_W];
      end
    end
  end

  // In MODE 1 the scan starts at 0, so the first hit is the lowest index.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (MODE == 1) scan_idx = PW'(k);
      else           scan_idx = PW'((int'(rr_ptr) + k) % N_MASTERS);
      if (!win_found && m_cyc[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign rr_next = (int'(win_idx) == N_MASTERS - 1) ? '0 : win_idx + PW'(1);

  // A strobe and an ack in the same cycle cancel each other. An ack with
  // nothing outstanding still reaches the owner, but the counter stays at 0.
  assign strb_acc = s_stb & ~s_stall;
  assign ack_in   = busy & s_ack;

  always_comb begin
    cnt_next = out_cnt;
    if (strb_acc && !ack_in)
      cnt_next = out_cnt + CW'(1);
    else if (ack_in && !strb_acc && out_cnt != '0)
      cnt_next = out_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_cnt <= '0;
          if (win_found) begin
            state <= GRANTED;
            grant <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
            if (MODE == 0) rr_ptr <= rr_next;
          end
        end
        GRANTED: begin
          // When the owner drops cyc, the tenure ends and any outstanding
          // acks are forgotten. The IDLE cycle that follows keeps tenures apart.
          if (!owner_cyc) begin
            state   <= IDLE;
            grant   <= '0;
            out_cnt <= '0;
          end else begin
            out_cnt <= cnt_next;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          out_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
module tb_wishbone_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic            s_ack, s_stall;
  logic [DW-1:0]   s_dat_r;

  logic [DW-1:0] m_dat_r0, m_dat_r1;
  logic [N-1:0]  m_ack0, m_ack1, m_stall0, m_stall1, grant0, grant1;
  logic          s_cyc0, s_cyc1, s_stb0, s_stb1, s_we0, s_we1, busy0, busy1;
  logic [AW-1:0] s_adr0, s_adr1;
  logic [DW-1:0] s_dat_w0, s_dat_w1;

  // dut0: round-robin, MAX_OUT 2; dut1: fixed priority, MAX_OUT 3
  wishbone_rr_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .MODE(0), .MAX_OUT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r0), .m_ack(m_ack0),
    .m_stall(m_stall0), .s_cyc(s_cyc0), .s_stb(s_stb0), .s_we(s_we0),
    .s_adr(s_adr0), .s_dat_w(s_dat_w0), .s_ack(s_ack), .s_stall(s_stall),
    .s_dat_r(s_dat_r), .grant(grant0), .busy(busy0));

  wishbone_rr_arbiter #(.N_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .MODE(1), .MAX_OUT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r1), .m_ack(m_ack1),
    .m_stall(m_stall1), .s_cyc(s_cyc1), .s_stb(s_stb1), .s_we(s_we1),
    .s_adr(s_adr1), .s_dat_w(s_dat_w1), .s_ack(s_ack), .s_stall(s_stall),
    .s_dat_r(s_dat_r), .grant(grant1), .busy(busy1));

  // Reference model: owner index (-1 = idle), next round-robin start, outstanding count
  int own[2];
  int ptr[2];
  int cnt[2];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic int max_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1;
      ptr[d] = 0;
      cnt[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (own[d] < 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (d == 1) ? k : (ptr[d] + k) % N;
          if (own[d] < 0 && m_cyc[i]) own[d] = i;
        end
        if (own[d] >= 0 && d == 0) ptr[d] = (own[d] + 1) % N;
        cnt[d] = 0;
      end else if (!m_cyc[own[d]]) begin
        own[d] = -1;
        cnt[d] = 0;
      end else begin
        bit acc;
        acc = m_stb[own[d]] && (cnt[d] < max_of(d)) && !s_stall;
        if (acc && !s_ack) cnt[d]++;
        else if (s_ack && !acc && cnt[d] > 0) cnt[d]--;
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0]  e_grant, e_stall, e_ack, g_grant, g_stall, g_ack;
      logic          e_scyc, e_sstb, e_swe, g_scyc, g_sstb, g_swe, g_busy;
      logic [AW-1:0] e_adr, g_adr;
      logic [DW-1:0] e_dat, g_dat, g_dr;
      int            g_cnt;
      e_grant = '0; e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_adr = '0; e_dat = '0;
      if (own[d] >= 0) begin
        e_grant[own[d]] = 1'b1;
        e_scyc = m_cyc[own[d]];
        e_sstb = m_stb[own[d]] && (cnt[d] < max_of(d));
        e_swe  = m_we[own[d]];
        e_adr  = m_adr[own[d]*AW +: AW];
        e_dat  = m_dat_w[own[d]*DW +: DW];
      end
      for (int i = 0; i < N; i++) begin
        e_stall[i] = (i != own[d]) || s_stall || (cnt[d] == max_of(d));
        e_ack[i]   = (i == own[d]) && s_ack;
      end
      if (d == 0) begin
        g_grant = grant0; g_stall = m_stall0; g_ack = m_ack0; g_scyc = s_cyc0;
        g_sstb = s_stb0; g_swe = s_we0; g_busy = busy0; g_adr = s_adr0;
        g_dat = s_dat_w0; g_dr = m_dat_r0; g_cnt = int'(dut0.out_cnt);
      end else begin
        g_grant = grant1; g_stall = m_stall1; g_ack = m_ack1; g_scyc = s_cyc1;
        g_sstb = s_stb1; g_swe = s_we1; g_busy = busy1; g_adr = s_adr1;
        g_dat = s_dat_w1; g_dr = m_dat_r1; g_cnt = int'(dut1.out_cnt);
      end
      chk($sformatf("d%0d grant", d),   64'(g_grant), 64'(e_grant));
      chk($sformatf("d%0d busy", d),    64'(g_busy),  64'(own[d] >= 0));
      chk($sformatf("d%0d s_cyc", d),   64'(g_scyc),  64'(e_scyc));
      chk($sformatf("d%0d s_stb", d),   64'(g_sstb),  64'(e_sstb));
      chk($sformatf("d%0d s_we", d),    64'(g_swe),   64'(e_swe));
      chk($sformatf("d%0d s_adr", d),   64'(g_adr),   64'(e_adr));
      chk($sformatf("d%0d s_dat_w", d), 64'(g_dat),   64'(e_dat));
      chk($sformatf("d%0d m_stall", d), 64'(g_stall), 64'(e_stall));
      chk($sformatf("d%0d m_ack", d),   64'(g_ack),   64'(e_ack));
      chk($sformatf("d%0d m_dat_r", d), 64'(g_dr),    64'(s_dat_r));
      chk($sformatf("d%0d out_cnt", d), 64'(g_cnt),   64'(cnt[d]));
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #2 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};
    m_dat_w = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
    s_ack = 1'b0; s_stall = 1'b0; s_dat_r = 16'h5A5A;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #2 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [5];
    seq = '{1, 2, 4, 8, 1};
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    do_reset();

    // Round-robin rotation with all four masters requesting
    m_cyc = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("rr_seq grant", 64'(grant0), 64'(seq[t]));
      m_stb = 4'b1111;
      step();
      m_stb = '0;
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      m_cyc = 4'b1111 & ~4'(seq[t]);
      step();
      chk("rr_gap grant", 64'(grant0), 64'(0));
      m_cyc = 4'b1111;
    end

    // Fixed priority
    do_reset();
    m_cyc = 4'b1010;
    step();
    chk("fp grant 1010", 64'(grant1), 64'(4'b0010));
    m_cyc = 4'b1000;
    step();
    chk("fp release", 64'(grant1), 64'(0));
    step();
    chk("fp grant 1000", 64'(grant1), 64'(4'b1000));

    // Outstanding limit and simultaneous strobe/ack
    do_reset();
    m_cyc = 4'b0001;
    step();
    m_stb = 4'b0001;
    step();
    step();
    chk("limit cnt2", 64'(dut0.out_cnt), 64'(2));
    chk("limit stall", 64'(m_stall0[0]), 64'(1));
    chk("limit s_stb", 64'(s_stb0), 64'(0));
    step();
    chk("limit hold", 64'(dut0.out_cnt), 64'(2));
    s_ack = 1'b1;
    step();
    chk("limit cnt1", 64'(dut0.out_cnt), 64'(1));
    s_ack = 1'b0;
    step();
    chk("limit cnt2b", 64'(dut0.out_cnt), 64'(2));
    m_stb = '0;
    s_ack = 1'b1;
    step();
    m_stb = 4'b0001;
    step();
    chk("same_cyc cnt1", 64'(dut0.out_cnt), 64'(1));
    s_ack = 1'b0;

    // Non-owner master 2 strobing during master 0's tenure
    m_cyc = 4'b0101;
    m_stb = 4'b0101;
    m_adr = {16'h3333, 16'hBEEF, 16'h1111, 16'h1234};
    for (int t = 0; t < 4; t++) begin
      s_ack = t[0];
      step();
      chk("m2 stall", 64'(m_stall0[2]), 64'(1));
      chk("m2 ack", 64'(m_ack0[2]), 64'(0));
      chk("m2 adr hidden", 64'(s_adr0 == 16'hBEEF), 64'(0));
    end
    s_ack = 1'b0;

    // Reset mid-tenure with two strobes outstanding
    do_reset();
    m_cyc = 4'b0001;
    step();
    m_stb = 4'b0001;
    step();
    step();
    chk("rst pre cnt", 64'(dut0.out_cnt), 64'(2));
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst grant", 64'(grant0), 64'(0));
    chk("rst s_cyc", 64'(s_cyc0), 64'(0));
    chk("rst stall", 64'(m_stall0), 64'(4'b1111));
    s_ack = 1'b1;
    #1 chk("rst late ack", 64'(m_ack0), 64'(0));
    @(negedge clk);
    #2 check_outputs();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
      m_stb   = 4'($urandom);
      m_we    = 4'($urandom);
      m_adr   = {$urandom, $urandom};
      m_dat_w = {$urandom, $urandom};
      s_ack   = ($urandom_range(0, 2) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat_r = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
